// File: rtl/alavanca2serial.sv
// -----------------------------------------------------------------------------
// alavanca2serial
//
// Serialises a snapshot of two signed 16-bit lever values as a UART (8N1)
// frame. A frame is the ASCII preamble "DATA" followed by al1 (low byte
// first) and al2 (low byte first). Bytes are sent back to back with no idle
// gap between them. TX idles high.
//
// Optional feature (macro ALAVANCA2SERIAL_CHECKSUM_EN):
//   When defined, a ninth byte is appended. It is the XOR of the eight
//   preceding bytes, and db_estado then reaches 8.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (434 = 50 MHz / 115200 baud)
//
// Ports:
//   clock     - system clock, rising edge active
//   reset     - asynchronous active-low reset
//   partida   - start request; accepted only while idle
//   al1Bits   - lever 1 value (signed, 16 bits)
//   al2Bits   - lever 2 value (signed, 16 bits)
//   TX        - serial output line, registered, idle high
//   ocupado   - high while a frame is on the line
//   pronto    - one-cycle pulse in the first cycle after the last stop bit
//   db_estado - byte index being sent while busy, 4'hF while idle
// -----------------------------------------------------------------------------
module alavanca2serial #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [15:0] al1Bits,
  input  logic [15:0] al2Bits,
  output logic        TX,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

`ifdef ALAVANCA2SERIAL_CHECKSUM_EN
  localparam logic [3:0] LAST_BYTE = 4'd8;
`else
  localparam logic [3:0] LAST_BYTE = 4'd7;
`endif

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    INICIO = 2'd1,
    DADOS  = 2'd2,
    PARADA = 2'd3
  } estado_t;

  estado_t       state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [2:0]    bit_r, bit_s;
  logic [3:0]    byte_r, byte_s;
  logic [15:0]   al1_r, al1_s;
  logic [15:0]   al2_r, al2_s;
  logic          tx_r, tx_s;
  logic          ocupado_r, ocupado_s;
  logic          pronto_r, pronto_s;
  logic [3:0]    db_r, db_s;
  logic [7:0]    cur_byte_s;
  logic [2:0]    nxt_bit_s;
  logic          timer_done_s;

`ifdef ALAVANCA2SERIAL_CHECKSUM_EN
  // XOR of the whole frame payload, preamble included
  function automatic logic [7:0] frame_checksum(input logic [15:0] a1,
                                                input logic [15:0] a2);
    return 8'h44 ^ 8'h41 ^ 8'h54 ^ 8'h41 ^
           a1[7:0] ^ a1[15:8] ^ a2[7:0] ^ a2[15:8];
  endfunction
`endif

  // Byte at position idx of the frame, built from the snapshot registers
  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [15:0] a1,
                                            input logic [15:0] a2);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h44;
      4'd1:    b = 8'h41;
      4'd2:    b = 8'h54;
      4'd3:    b = 8'h41;
      4'd4:    b = a1[7:0];
      4'd5:    b = a1[15:8];
      4'd6:    b = a2[7:0];
      4'd7:    b = a2[15:8];
`ifdef ALAVANCA2SERIAL_CHECKSUM_EN
      4'd8:    b = frame_checksum(a1, a2);
`endif
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  // Next-state and next-output logic; TX is computed one cycle ahead so that
  // the registered line changes exactly on bit boundaries
  always_comb begin
    state_s      = state_r;
    timer_s      = timer_r;
    bit_s        = bit_r;
    byte_s       = byte_r;
    al1_s        = al1_r;
    al2_s        = al2_r;
    tx_s         = tx_r;
    ocupado_s    = ocupado_r;
    pronto_s     = 1'b0;
    nxt_bit_s    = bit_r + 3'd1;
    cur_byte_s   = frame_byte(byte_r, al1_r, al2_r);
    timer_done_s = (timer_r == TIMER_LAST);

    case (state_r)
      OCIOSO: begin
        timer_s   = '0;
        bit_s     = 3'd0;
        byte_s    = 4'd0;
        tx_s      = 1'b1;
        ocupado_s = 1'b0;
        if (partida) begin
          state_s   = INICIO;
          al1_s     = al1Bits;
          al2_s     = al2Bits;
          tx_s      = 1'b0;
          ocupado_s = 1'b1;
        end else begin
          state_s   = OCIOSO;
        end
      end

      INICIO: begin
        if (timer_done_s) begin
          state_s = DADOS;
          timer_s = '0;
          bit_s   = 3'd0;
          tx_s    = cur_byte_s[0];
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end

      DADOS: begin
        if (timer_done_s) begin
          timer_s = '0;
          if (bit_r == 3'd7) begin
            state_s = PARADA;
            tx_s    = 1'b1;
          end else begin
            bit_s   = nxt_bit_s;
            tx_s    = cur_byte_s[nxt_bit_s];
          end
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end

      PARADA: begin
        if (timer_done_s) begin
          timer_s = '0;
          if (byte_r == LAST_BYTE) begin
            // Frame complete: the following cycle is idle and flags pronto
            state_s   = OCIOSO;
            byte_s    = 4'd0;
            bit_s     = 3'd0;
            tx_s      = 1'b1;
            ocupado_s = 1'b0;
            pronto_s  = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no gap
            state_s = INICIO;
            byte_s  = byte_r + 4'd1;
            tx_s    = 1'b0;
          end
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end

      default: begin
        state_s   = OCIOSO;
        timer_s   = '0;
        bit_s     = 3'd0;
        byte_s    = 4'd0;
        tx_s      = 1'b1;
        ocupado_s = 1'b0;
      end
    endcase

    db_s = ocupado_s ? byte_s : 4'hF;
  end

  // State, counters, snapshot and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= OCIOSO;
      timer_r   <= '0;
      bit_r     <= 3'd0;
      byte_r    <= 4'd0;
      al1_r     <= 16'd0;
      al2_r     <= 16'd0;
      tx_r      <= 1'b1;
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
      db_r      <= 4'hF;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      bit_r     <= bit_s;
      byte_r    <= byte_s;
      al1_r     <= al1_s;
      al2_r     <= al2_s;
      tx_r      <= tx_s;
      ocupado_r <= ocupado_s;
      pronto_r  <= pronto_s;
      db_r      <= db_s;
    end
  end

  assign TX        = tx_r;
  assign ocupado   = ocupado_r;
  assign pronto    = pronto_r;
  assign db_estado = db_r;

endmodule

// File: tb/tb_alavanca2serial.sv
// -----------------------------------------------------------------------------
// tb_alavanca2serial
//
// Self-checking bench for alavanca2serial with CLKS_PER_BIT=4. A frame model
// predicts, for every cycle, the line level, ocupado, pronto and db_estado
// from the accepted start cycle and the snapshotted bytes. A UART decoder
// turns TX back into bytes, which are compared against the predicted byte
// stream and fed to a DATA-preamble lever receiver model for loopback.
// Honours ALAVANCA2SERIAL_CHECKSUM_EN (nine-byte frames).
// -----------------------------------------------------------------------------
module tb_alavanca2serial;

  localparam int C = 4;
`ifdef ALAVANCA2SERIAL_CHECKSUM_EN
  localparam int NB      = 9;
  localparam int EXP_LEN = 360;
`else
  localparam int NB      = 8;
  localparam int EXP_LEN = 320;
`endif
  localparam int FL = NB * 10 * C;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        partida = 1'b0;
  logic [15:0] al1Bits = 16'h0000;
  logic [15:0] al2Bits = 16'h0000;
  logic        TX;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  alavanca2serial #(.CLKS_PER_BIT(C)) dut (
    .clock     (clock),
    .reset     (reset),
    .partida   (partida),
    .al1Bits   (al1Bits),
    .al2Bits   (al2Bits),
    .TX        (TX),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // frame model
  bit         m_act = 1'b0;
  int         m_t0  = 0;
  logic [7:0] m_bytes [0:8];
  logic [7:0] exp_q [$];

  // UART decoder and measurements
  bit         mon_busy = 1'b0;
  int         mon_cnt  = 0;
  logic [7:0] mon_sh   = 8'h00;
  logic [7:0] log_q [$];
  logic       prev_tx = 1'b1;
  logic       prev_oc = 1'b0;
  int         frame_start_cyc = -1;
  int         pronto_cyc = -1;
  int         pronto_count = 0;
  int         starts_q [$];
  int         prontos_q [$];

  // lever receiver model
  int          rx_st = 0;
  logic [7:0]  rx_buf [0:3];
  logic [15:0] rx_al1 = 16'h0000;
  logic [15:0] rx_al2 = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic got_byte(input logic [7:0] b);
    log_q.push_back(b);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_byte: got %0h want none (cycle %0d)", b, cyc);
    end else begin
      chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
    end
    // DATA-preamble receiver: a new 'D' publishes the previously collected values
    if (rx_st >= 4 && rx_st <= 7) begin
      rx_buf[rx_st - 4] = b;
      rx_st++;
    end else if (b == 8'h44) begin
      if (rx_st == 8) begin
        rx_al1 = {rx_buf[1], rx_buf[0]};
        rx_al2 = {rx_buf[3], rx_buf[2]};
      end
      rx_st = 1;
    end else if (rx_st == 1 && b == 8'h41) begin
      rx_st = 2;
    end else if (rx_st == 2 && b == 8'h54) begin
      rx_st = 3;
    end else if (rx_st == 3 && b == 8'h41) begin
      rx_st = 4;
    end else if (rx_st != 8) begin
      rx_st = 0;
    end
  endtask

  // Decoder, measurements, model prediction and per-cycle comparison
  always @(negedge clock) begin
    logic       e_tx;
    logic       e_oc;
    logic       e_pr;
    logic [3:0] e_db;
    int         k;
    int         w;
    int         b;
    cyc++;

    if (reset !== 1'b1) begin
      mon_busy = 1'b0;
      m_act    = 1'b0;
      rx_st    = 0;
      exp_q.delete();
    end else if (!mon_busy) begin
      if (TX === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == C / 2) chk("start_bit", 32'(TX), 32'd0);
      if (mon_cnt >= C && mon_cnt < 9 * C && (mon_cnt % C) == C / 2)
        mon_sh = {TX, mon_sh[7:1]};
      if (mon_cnt == 9 * C + C / 2) begin
        chk("stop_bit", 32'(TX), 32'd1);
        mon_busy = 1'b0;
        got_byte(mon_sh);
      end
    end

    if (reset === 1'b1 && prev_tx === 1'b1 && TX === 1'b0 && prev_oc === 1'b0) begin
      frame_start_cyc = cyc;
      starts_q.push_back(cyc);
    end
    if (pronto === 1'b1) begin
      pronto_count++;
      pronto_cyc = cyc;
      prontos_q.push_back(cyc);
    end
    prev_tx = TX;
    prev_oc = ocupado;

    // what the line must look like in this cycle
    e_tx = 1'b1;
    e_oc = 1'b0;
    e_pr = 1'b0;
    e_db = 4'hF;
    k = cyc - m_t0;
    if (reset === 1'b1 && m_act) begin
      if (k >= 0 && k < FL) begin
        b    = k / (10 * C);
        w    = (k / C) % 10;
        e_oc = 1'b1;
        e_db = 4'(b);
        if (w == 0)      e_tx = 1'b0;
        else if (w == 9) e_tx = 1'b1;
        else             e_tx = m_bytes[b][w - 1];
      end else if (k == FL) begin
        e_pr = 1'b1;
      end
    end
    chk("TX", 32'(TX), 32'(e_tx));
    chk("ocupado", 32'(ocupado), 32'(e_oc));
    chk("pronto", 32'(pronto), 32'(e_pr));
    chk("db_estado", 32'(db_estado), 32'(e_db));

    // a request seen while idle starts a frame in the next cycle
    if (reset === 1'b1 && partida === 1'b1 && e_oc == 1'b0) begin
      m_act = 1'b1;
      m_t0  = cyc + 1;
      m_bytes[0] = 8'h44;
      m_bytes[1] = 8'h41;
      m_bytes[2] = 8'h54;
      m_bytes[3] = 8'h41;
      m_bytes[4] = al1Bits[7:0];
      m_bytes[5] = al1Bits[15:8];
      m_bytes[6] = al2Bits[7:0];
      m_bytes[7] = al2Bits[15:8];
      m_bytes[8] = 8'h00;
      for (int i = 0; i < 8; i++) m_bytes[8] = m_bytes[8] ^ m_bytes[i];
      for (int i = 0; i < NB; i++) exp_q.push_back(m_bytes[i]);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_pronto(input string nm, input int budget);
    int start;
    int n;
    start = pronto_count;
    n = 0;
    while (pronto_count == start && n < budget) begin
      step();
      n++;
    end
    total++;
    if (pronto_count == start) begin
      bad++;
      $display("FAIL %s: no pronto within %0d cycles", nm, budget);
    end
  endtask

  task automatic pulse(input logic [15:0] a1, input logic [15:0] a2);
    al1Bits = a1;
    al2Bits = a2;
    partida = 1'b1;
    step();
    partida = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp1 [0:8];
    logic [15:0] a1;
    logic [15:0] a2;
    int          pc0;
    int          n;
    int          r;
    exp1[0] = 8'h44; exp1[1] = 8'h41; exp1[2] = 8'h54; exp1[3] = 8'h41;
    exp1[4] = 8'h34; exp1[5] = 8'h12; exp1[6] = 8'h80; exp1[7] = 8'hFF;
    exp1[8] = 8'h49;

    // reset state
    @(negedge clock);
    chk("rst_TX", 32'(TX), 32'd1);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_db", 32'(db_estado), 32'hF);
    step();
    step();
    reset = 1'b1;
    step();
    step();

    // basic frame, length and single pronto
    log_q.delete();
    pc0 = pronto_count;
    pulse(16'h1234, 16'hFF80);
    wait_pronto("s1_pronto", FL + 20);
    repeat (5) step();
    chk("s1_pronto_once", 32'(pronto_count - pc0), 32'd1);
    chk("s1_len", 32'(pronto_cyc - frame_start_cyc), 32'(EXP_LEN));
    chk("s1_nbytes", 32'(log_q.size()), 32'(NB));
    for (int i = 0; i < NB && i < log_q.size(); i++)
      chk("s1_byte", 32'(log_q[i]), 32'(exp1[i]));

    // re-request and input change mid-frame
    log_q.delete();
    pc0 = pronto_count;
    pulse(16'h1234, 16'hFF80);
    repeat (100) step();
    al1Bits = 16'h7FFF;
    partida = 1'b1;
    repeat (5) step();
    partida = 1'b0;
    wait_pronto("s2_pronto", FL);
    repeat (30 * C) step();
    chk("s2_one_frame", 32'(pronto_count - pc0), 32'd1);
    chk("s2_idle", 32'(ocupado), 32'd0);
    chk("s2_nbytes", 32'(log_q.size()), 32'(NB));
    for (int i = 4; i < 8 && i < log_q.size(); i++)
      chk("s2_byte", 32'(log_q[i]), 32'(exp1[i]));

    // reset during byte 5, then a request right after release
    pulse(16'h1234, 16'hFF80);
    n = 0;
    while (db_estado !== 4'd5 && n < FL) begin
      step();
      n++;
    end
    chk("s3_reach_byte5", 32'(db_estado), 32'd5);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("s3_async_TX", 32'(TX), 32'd1);
    chk("s3_async_ocupado", 32'(ocupado), 32'd0);
    chk("s3_async_db", 32'(db_estado), 32'hF);
    repeat (3) step();
    log_q.delete();
    reset = 1'b1;
    pulse(16'h8000, 16'h0001);
    wait_pronto("s3_pronto", FL + 20);
    repeat (3) step();
    chk("s3_nbytes", 32'(log_q.size()), 32'(NB));
    if (log_q.size() >= 8) begin
      chk("s3_b4", 32'(log_q[4]), 32'h00);
      chk("s3_b5", 32'(log_q[5]), 32'h80);
      chk("s3_b6", 32'(log_q[6]), 32'h01);
      chk("s3_b7", 32'(log_q[7]), 32'h00);
    end

    // partida held high: back-to-back frames with one idle cycle between
    starts_q.delete();
    prontos_q.delete();
    pc0 = pronto_count;
    partida = 1'b1;
    n = 0;
    while (pronto_count - pc0 < 2 && n < 3 * FL) begin
      al1Bits = 16'($urandom);
      al2Bits = 16'($urandom);
      step();
      n++;
    end
    partida = 1'b0;
    chk("s4_two_frames", 32'(pronto_count - pc0), 32'd2);
    wait_pronto("s4_third", FL + 20);
    repeat (3) step();
    chk("s4_starts", 32'(starts_q.size()), 32'd3);
    if (starts_q.size() >= 3 && prontos_q.size() >= 2) begin
      chk("s4_gap1", 32'(starts_q[1] - prontos_q[0]), 32'd1);
      chk("s4_gap2", 32'(starts_q[2] - prontos_q[1]), 32'd1);
    end

    // randomized frames with random idle gaps and ignored mid-frame requests
    for (int it = 0; it < 5; it++) begin
      repeat ($urandom_range(0, 30)) step();
      pulse(16'($urandom), 16'($urandom));
      r = $urandom_range(1, FL - 10);
      repeat (r) step();
      al1Bits = 16'($urandom);
      partida = 1'b1;
      step();
      partida = 1'b0;
      wait_pronto("rnd_pronto", FL);
    end

    // loopback: the receiver publishes a frame's values on the next 'D'
    a1 = 16'($urandom);
    a2 = 16'($urandom);
    step();
    pulse(a1, a2);
    wait_pronto("lb_first", FL + 20);
    pulse(16'($urandom), 16'($urandom));
    wait_pronto("lb_second", FL + 20);
    repeat (3) step();
    chk("lb_al1", 32'(rx_al1), 32'(a1));
    chk("lb_al2", 32'(rx_al2), 32'(a2));

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
